// File: rtl/vdp_clk_pkg.sv
// Shared clocking definitions for the video PLL domain: sequencer state type
// and default 27 MHz timing constants.
package vdp_clk_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_t;

  localparam int unsigned PLL_RST_CYC     = 27;
  localparam int unsigned PLL_STABLE_CYC  = 2700;
  localparam int unsigned PLL_TIMEOUT_CYC = 270000;
  localparam int unsigned PLL_MAX_RETRIES = 3;

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
interface pll_lock_sequencer_if;
  logic       pll_lock;
  logic       force_relock;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic [3:0] lost_count;
  logic [2:0] state_o;

  modport master (
    output pll_lock, force_relock,
    input  pll_reset, sys_reset, ready, fault, lost_count, state_o
  );

  modport slave (
    input  pll_lock, force_relock,
    output pll_reset, sys_reset, ready, fault, lost_count, state_o
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchroniser, cleared to 0 by synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// Video PLL power-up/recovery sequencer: drives PLL reset, qualifies lock,
// holds system reset until lock is stable and re-sequences on lock loss.
module pll_lock_sequencer
  import vdp_clk_pkg::*;
#(
  parameter int unsigned RESET_CYCLES        = PLL_RST_CYC,
  parameter int unsigned LOCK_STABLE_CYCLES  = PLL_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = PLL_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRIES         = PLL_MAX_RETRIES
) (
  input logic clk,
  input logic reset,
  pll_lock_sequencer_if.slave bus
);
  localparam int unsigned TMR_MAX = (LOCK_TIMEOUT_CYCLES > RESET_CYCLES) ?
                                    LOCK_TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int unsigned TW = $clog2(TMR_MAX + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  pll_seq_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [SW-1:0]  stable_q, stable_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           low_q, low_d;
  logic [3:0]     lost_q, lost_d;
  logic           lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.pll_lock),
    .q_o   (lock_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RESET_PLL;
      timer_q  <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      low_q    <= 1'b0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      low_q    <= low_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    low_d    = low_q;
    lost_d   = lost_q;
    if (bus.force_relock) begin
      state_d  = RESET_PLL;
      timer_d  = '0;
      stable_d = '0;
      retry_d  = '0;
      low_d    = 1'b0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (timer_q == TW'(RESET_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d  = STABLE;
            stable_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            timer_d = '0;
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == RW'(MAX_RETRIES)) ? FAULT : RESET_PLL;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (stable_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = RUN;
            retry_d = '0;
          end else begin
            stable_d = stable_q + 1'b1;
          end
        end
        RUN: begin
          // low_q remembers one low lock_s cycle so single glitches are ignored
          low_d = !lock_s;
          if (!lock_s && low_q) begin
            state_d = RESET_PLL;
            timer_d = '0;
            low_d   = 1'b0;
            if (lost_q != 4'hF) lost_d = lost_q + 1'b1;
          end
        end
        FAULT: begin
        end
        default: state_d = RESET_PLL;
      endcase
    end
  end

  assign bus.pll_reset  = (state_q == RESET_PLL) || (state_q == FAULT);
  assign bus.sys_reset  = (state_q != RUN);
  assign bus.ready      = (state_q == RUN);
  assign bus.fault      = (state_q == FAULT);
  assign bus.lost_count = lost_q;
  assign bus.state_o    = state_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed vector table, hand
// sequences for saturation/reset, and random stimulus against a cycle model.
module tb_pll_lock_sequencer;
  localparam int P_RC = 4;
  localparam int P_ST = 8;
  localparam int P_TO = 32;
  localparam int P_MR = 2;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RESET_CYCLES        (P_RC),
    .LOCK_STABLE_CYCLES  (P_ST),
    .LOCK_TIMEOUT_CYCLES (P_TO),
    .MAX_RETRIES         (P_MR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        l;
    logic        f;
    int unsigned n;
    logic [2:0]  st;
    logic        pr;
    logic        sr;
    logic        rdy;
    logic        flt;
    logic [3:0]  lost;
  } vec_t;

  vec_t tbl[$];

  // Reference model: mode number, edges spent in the current mode,
  // failed attempts, consecutive low lock samples in RUN, losses seen.
  int m_state, m_el, m_fails, m_low, m_lost;
  int s1, s2;

  function automatic vec_t mk(logic r, logic l, logic f, int unsigned n, logic [2:0] st,
                              logic pr, logic sr, logic rdy, logic flt, logic [3:0] lost);
    vec_t v;
    v.r = r; v.l = l; v.f = f; v.n = n; v.st = st;
    v.pr = pr; v.sr = sr; v.rdy = rdy; v.flt = flt; v.lost = lost;
    return v;
  endfunction

  function automatic logic [10:0] dut_pack();
    return {bus.state_o, bus.pll_reset, bus.sys_reset, bus.ready, bus.fault, bus.lost_count};
  endfunction

  function automatic logic [10:0] model_pack();
    logic [2:0] st;
    logic [3:0] lc;
    st = 3'(m_state);
    lc = 4'(m_lost);
    return {st, (m_state == 0 || m_state == 4), (m_state != 3), (m_state == 3),
            (m_state == 4), lc};
  endfunction

  function automatic void model_step(logic r, logic l, logic f);
    int lk;
    lk = s2;
    s2 = s1;
    s1 = int'(l);
    if (r) begin
      m_state = 0; m_el = 0; m_fails = 0; m_low = 0; m_lost = 0; s1 = 0; s2 = 0;
    end else if (f) begin
      m_state = 0; m_el = 0; m_fails = 0; m_low = 0;
    end else begin
      case (m_state)
        0: begin
          m_el++;
          if (m_el == P_RC) begin m_state = 1; m_el = 0; end
        end
        1: begin
          if (lk != 0) begin
            m_state = 2; m_el = 0;
          end else begin
            m_el++;
            if (m_el == P_TO) begin
              m_fails++;
              m_state = (m_fails >= P_MR) ? 4 : 0;
              m_el = 0;
            end
          end
        end
        2: begin
          if (lk == 0) begin
            m_state = 1; m_el = 0;
          end else begin
            m_el++;
            if (m_el == P_ST) begin m_state = 3; m_el = 0; m_fails = 0; end
          end
        end
        3: begin
          if (lk == 0) begin
            m_low++;
            if (m_low == 2) begin
              m_state = 0; m_el = 0; m_low = 0;
              if (m_lost < 15) m_lost++;
            end
          end else begin
            m_low = 0;
          end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got {st,pr,sr,rdy,flt,lost}=%b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic f);
    reset = r;
    bus.pll_lock = l;
    bus.force_relock = f;
    @(posedge clk);
    model_step(r, l, f);
    #1;
    check("model", dut_pack(), model_pack());
  endtask

  initial begin
    logic lv;
    int   len;
    int   sel;
    logic rr;
    logic ff;
    n_tests = 0;
    n_fail = 0;
    m_state = 0; m_el = 0; m_fails = 0; m_low = 0; m_lost = 0; s1 = 0; s2 = 0;
    reset = 1'b1;
    bus.pll_lock = 1'b0;
    bus.force_relock = 1'b0;

    //                r   l   f   n     st  pr  sr  rdy flt lost
    tbl.push_back(mk(1, 0, 0, 2,    0, 1, 1, 0, 0, 0));   // reset state
    tbl.push_back(mk(0, 0, 0, 3,    0, 1, 1, 0, 0, 0));   // pll_reset still high
    tbl.push_back(mk(0, 0, 0, 1,    1, 0, 1, 0, 0, 0));   // falls after 4 cycles
    tbl.push_back(mk(0, 0, 0, 9,    1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2,    1, 0, 1, 0, 0, 0));   // 2-flop sync latency
    tbl.push_back(mk(0, 1, 0, 1,    2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 7,    2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1,    3, 0, 0, 1, 0, 0));   // RUN after 8 stable
    tbl.push_back(mk(0, 0, 0, 1,    3, 0, 0, 1, 0, 0));   // RUN glitch
    tbl.push_back(mk(0, 1, 0, 4,    3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 3,    3, 0, 0, 1, 0, 0));   // lock loss
    tbl.push_back(mk(0, 1, 0, 1,    0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 3,    0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1,    1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1,    2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 3,    2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1,    2, 0, 1, 0, 0, 1));   // STABLE glitch
    tbl.push_back(mk(0, 1, 0, 2,    1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1,    2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 7,    2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1,    3, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 3,    3, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1,    0, 1, 1, 0, 0, 1));   // force beats loss
    tbl.push_back(mk(0, 1, 0, 4,    1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1,    2, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 8,    3, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 3,    3, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1,    0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 3,    0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1,    1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 31,   1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1,    0, 1, 1, 0, 0, 2));   // first timeout
    tbl.push_back(mk(0, 0, 0, 4,    1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 31,   1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1,    4, 1, 1, 0, 1, 2));   // second timeout
    tbl.push_back(mk(0, 0, 0, 1000, 4, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 1, 1,    0, 1, 1, 0, 0, 2));   // force out of FAULT
    tbl.push_back(mk(0, 0, 0, 4,    1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 31,   1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1,    0, 1, 1, 0, 0, 2));   // retries were cleared
    tbl.push_back(mk(0, 1, 0, 4,    1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 1,    2, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 8,    3, 0, 0, 1, 0, 2));

    foreach (tbl[i]) begin
      repeat (tbl[i].n) cyc(tbl[i].r, tbl[i].l, tbl[i].f);
      check($sformatf("vec%0d", i), dut_pack(),
            {tbl[i].st, tbl[i].pr, tbl[i].sr, tbl[i].rdy, tbl[i].flt, tbl[i].lost});
    end

    // 17 further lock losses: counter must saturate
    repeat (17) begin
      repeat (4) cyc(0, 0, 0);
      repeat (20) cyc(0, 1, 0);
    end
    check("lost_sat", dut_pack(), {3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15});

    // reset in the middle of STABLE
    repeat (4) cyc(0, 0, 0);
    repeat (6) cyc(0, 1, 0);
    check("pre_reset_stable", dut_pack(), {3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15});
    cyc(1, 1, 0);
    check("mid_stable_reset", dut_pack(), {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0});

    for (int seg = 0; seg < 150; seg++) begin
      lv  = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      len = int'($urandom_range(1, 4));
      else if (sel < 8) len = int'($urandom_range(10, 30));
      else              len = int'($urandom_range(30, 90));
      for (int k = 0; k < len; k++) begin
        ff = ($urandom_range(0, 99) == 0);
        rr = ($urandom_range(0, 499) == 0);
        cyc(rr, lv, ff);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
